alu_writeback_stage: RTL
========================

// Module: alu_writeback_stage
// PURPOSE
// - Pipeline stage directly downstream of the 16-bit ALU; registers ALU result + ZF/CF/NF/OF per issued op.
// - Maintains architectural status register {OF,NF,CF,ZF}; presents register-file writes with valid/ready back-pressure.
// - 2-entry skid buffer decouples ALU issue from writeback stalls; no combinational ready path upstream.
// PARAMETERS
// - DATA_W   16  result width written back (ALU result bit 16 carries CF only, never written)
// - REG_AW   3   destination register index width
// - CNT_W    16  retired-op counter width
// PORTS
// - clk          in   1        single clock, rising edge
// - rst          in   1        synchronous, active-high reset
// - in_valid     in   1        ALU output valid this cycle
// - in_ready     out  1        stage can accept; registered (= skid entry empty)
// - in_opcode    in   6        opcode the ALU executed (ALU encoding 6'b001001..6'b011010)
// - in_rd        in   REG_AW   destination register index
// - in_result    in   17       ALU result, bit 16 = carry-out
// - in_zf/cf/nf/of in 1 each   ALU flags
// - flush        in   1        drop all buffered ops; flags/counter kept
// - wb_valid     out  1        writeback entry valid
// - wb_ready     in   1        register file accepts
// - wb_we        out  1        1 = write wb_data to wb_rd; 0 = flag-only op (CMP/TST)
// - wb_rd        out  REG_AW   destination index
// - wb_data      out  DATA_W   in_result[15:0]
// - flags_q      out  4        {OF,NF,CF,ZF} status register
// - illegal_op   out  1        one-cycle pulse: accepted opcode outside 6'b001001..6'b011010
// - retired_cnt  out  CNT_W    count of entries popped to writeback, wraps to 0
// BEHAVIOUR
// - Reset: wb_valid=0, in_ready=1, wb_we=0, wb_rd=0, wb_data=0, flags_q=4'b0000, illegal_op=0, retired_cnt=0; both entries empty.
// - Accept = in_valid & in_ready. Push = accept & legal opcode. Pop = wb_valid & wb_ready.
// - Storage: output reg (OUT) + skid reg (SKID). States: EMPTY, ONE (OUT full), TWO (OUT+SKID full).
//   EMPTY: push -> ONE. ONE: push&!pop -> TWO; pop&!push -> EMPTY; push&pop -> ONE (OUT reloaded).
//   TWO: pop -> ONE (SKID moves to OUT); in_ready=0 so no push.
// - in_ready = (state != TWO), registered. Latency: push at edge N -> wb_valid high after edge N, for EMPTY/ONE-with-pop.
// - Order strictly preserved; an entry is held stable on wb_* while wb_valid & !wb_ready.
// - wb_we = 0 for CMP (6'b010111) and TST (6'b011000); 1 for every other legal opcode.
// - flags_q updated at the accept edge (not at pop) with in_{of,nf,cf,zf} for every legal opcode, incl. CMP/TST.
// - Illegal opcode: accepted (consumed) but not pushed; flags_q unchanged; illegal_op=1 for the next cycle only.
// - retired_cnt += 1 per pop; 2^CNT_W-1 + 1 -> 0.
// - flush (no reset): next state EMPTY, wb_valid=0, in_ready=1; a same-cycle accept is discarded but its flags
//   still commit; a same-cycle pop still counts. flush has priority over push.
// - rst mid-transfer: all entries discarded, outputs to reset values next edge; rst has priority over flush.
// - wb_data is in_result[15:0] unmodified; no sign/zero extension or saturation in this stage.
// STRUCTURE
// - Shared package alu_pkg: opcode localparams (OP_ADD=6'b001001 ... OP_DEC=6'b011010), OP_MIN/OP_MAX,
//   flag bit positions (FLG_Z=0, FLG_C=1, FLG_N=2, FLG_O=3), function is_flag_only(opcode).
// - One sub-module: wb_skid_buffer (2-entry, width REG_AW+1+DATA_W, valid/ready both sides).
// - Top: opcode decode, flags register, illegal pulse, retired counter.
// TESTING
// - Reset then ADD result 17'h00013, rd=2, wb_ready=1 -> wb_valid next cycle, wb_we=1, wb_rd=2, wb_data=16'h0013, flags_q=0.
// - wb_ready=0, issue 3 back-to-back ops -> two held, in_ready=0 after 2nd; release -> popped in order, retired_cnt=2.
// - CMP with nf=1 -> wb_we=0, flags_q=4'b0100; following SUB zf=1 -> flags_q=4'b0001.
// - Opcode 6'b000000 with in_valid -> no wb_valid, flags_q unchanged, illegal_op high exactly 1 cycle.
// - State TWO + flush with in_valid -> wb_valid=0, in_ready=1 next cycle, flags_q from that op committed.
// - Preload retired_cnt to 16'hFFFF via 65535 pops, one more pop -> retired_cnt=0; rst mid-stall -> all reset values.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, status flag bit positions,
// opcode classification helpers and the writeback skid buffer state type.
package alu_pkg;

   localparam logic [5:0] OP_ADD = 6'b001001;
   localparam logic [5:0] OP_SUB = 6'b001010;
   localparam logic [5:0] OP_CMP = 6'b010111;
   localparam logic [5:0] OP_TST = 6'b011000;
   localparam logic [5:0] OP_DEC = 6'b011010;

   localparam logic [5:0] OP_MIN = OP_ADD;
   localparam logic [5:0] OP_MAX = OP_DEC;

   localparam int FLG_Z = 0;
   localparam int FLG_C = 1;
   localparam int FLG_N = 2;
   localparam int FLG_O = 3;

   typedef enum logic [1:0] {
      SKID_EMPTY = 2'd0,
      SKID_ONE   = 2'd1,
      SKID_TWO   = 2'd2
   } skid_state_e;

   // Compare and test only update the flags; they never write a register.
   function automatic logic is_flag_only(input logic [5:0] opcode);
      return (opcode == OP_CMP) || (opcode == OP_TST);
   endfunction

   // Anything outside the ALU's contiguous opcode range is illegal.
   function automatic logic is_legal_op(input logic [5:0] opcode);
      return (opcode >= OP_MIN) && (opcode <= OP_MAX);
   endfunction

endpackage

// File: rtl/wb_skid_buffer.sv
// Two-entry skid buffer: an output register that drives the consumer and a
// skid register that catches one extra entry while the consumer stalls.
// ready_o depends only on registered state, so no combinational path runs
// from the downstream ready back to the upstream ready.
module wb_skid_buffer
   import alu_pkg::*;
#(
   parameter int W = 20
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         valid_i,
   output logic         ready_o,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   input  logic         ready_i,
   output logic [W-1:0] data_o
);

   skid_state_e stateQ;
   logic [W-1:0] outQ;
   logic [W-1:0] skidQ;
   logic         push;
   logic         pop;

   assign ready_o = (stateQ != SKID_TWO);
   assign valid_o = (stateQ != SKID_EMPTY);
   assign data_o  = outQ;
   assign push    = valid_i & ready_o;
   assign pop     = valid_o & ready_i;

   // Occupancy FSM: the output register always holds the oldest entry; the
   // skid register only fills when a push arrives while the output stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ <= SKID_EMPTY;
         outQ   <= '0;
         skidQ  <= '0;
      end else if (flush_i) begin
         stateQ <= SKID_EMPTY;
      end else begin
         case (stateQ)
            SKID_EMPTY: begin
               if (push) begin
                  outQ   <= data_i;
                  stateQ <= SKID_ONE;
               end
            end
            SKID_ONE: begin
               if (push && pop) begin
                  outQ <= data_i;
               end else if (push) begin
                  skidQ  <= data_i;
                  stateQ <= SKID_TWO;
               end else if (pop) begin
                  stateQ <= SKID_EMPTY;
               end
            end
            SKID_TWO: begin
               if (pop) begin
                  outQ   <= skidQ;
                  stateQ <= SKID_ONE;
               end
            end
            default: stateQ <= SKID_EMPTY;
         endcase
      end
   end

endmodule

// File: rtl/alu_writeback_stage.sv
// Writeback stage behind the 16-bit ALU: decodes the opcode, keeps the
// architectural {OF,NF,CF,ZF} status register, flags illegal opcodes and
// counts retired writebacks. Buffering lives in wb_skid_buffer.
module alu_writeback_stage
   import alu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_opcode,
   input  logic [REG_AW-1:0] in_rd,
   input  logic [16:0]       in_result,
   input  logic              in_zf,
   input  logic              in_cf,
   input  logic              in_nf,
   input  logic              in_of,
   input  logic              flush,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic              wb_we,
   output logic [REG_AW-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic [3:0]        flags_q,
   output logic              illegal_op,
   output logic [CNT_W-1:0]  retired_cnt
);

   localparam int ENTRY_W = 1 + REG_AW + DATA_W;

   logic               legalOp;
   logic               accept;
   logic               pop;
   logic [ENTRY_W-1:0] entryIn;
   logic [ENTRY_W-1:0] entryOut;
   logic [3:0]         flagsD;
   logic               unusedCarryOut;

   assign unusedCarryOut = in_result[16];

   assign legalOp = is_legal_op(in_opcode);
   assign accept  = in_valid & in_ready;
   assign pop     = wb_valid & wb_ready;
   assign entryIn = {~is_flag_only(in_opcode), in_rd, in_result[DATA_W-1:0]};

   assign wb_we   = entryOut[ENTRY_W-1];
   assign wb_rd   = entryOut[DATA_W +: REG_AW];
   assign wb_data = entryOut[DATA_W-1:0];

   wb_skid_buffer #(
      .W(ENTRY_W)
   ) skidBuffer (
      .clk    (clk),
      .rst    (rst),
      .flush_i(flush),
      .valid_i(in_valid & legalOp),
      .ready_o(in_ready),
      .data_i (entryIn),
      .valid_o(wb_valid),
      .ready_i(wb_ready),
      .data_o (entryOut)
   );

   // Pack the incoming ALU flags into their status register bit positions.
   always_comb begin
      flagsD        = '0;
      flagsD[FLG_Z] = in_zf;
      flagsD[FLG_C] = in_cf;
      flagsD[FLG_N] = in_nf;
      flagsD[FLG_O] = in_of;
   end

   // Flags commit when a legal op is accepted, even if a flush drops the op.
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= '0;
      end else if (accept && legalOp) begin
         flags_q <= flagsD;
      end
   end

   // An accepted illegal opcode is consumed silently apart from this pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_op <= 1'b0;
      end else begin
         illegal_op <= accept & ~legalOp;
      end
   end

   // Every entry handed to the register file counts, including on a flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired_cnt <= '0;
      end else if (pop) begin
         retired_cnt <= retired_cnt + 1'b1;
      end
   end

endmodule
